fifo1_enq_arbiter: RTL and testbench

//  Round-robin arbiter sharing the enq method of one single-entry FIFO (Fifo1: enq/enq__RDY/enq_v) among NREQ requesters.

---
 rtl/fifo1_enq_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_fifo1_enq_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo1_enq_arbiter.sv
// -----------------------------------------------------------------------------
// fifo1_enq_arbiter
//   Round-robin arbiter that shares the enq method of one single-entry FIFO
//   (Fifo1) among NREQ requesters. A grant may be held for up to MAXBURST
//   consecutive enqueues so that a burst from one source stays contiguous in
//   the FIFO stream. All method outputs are combinational from registered
//   state and the current inputs (zero latency), so RDY and the forwarded ENA
//   always agree within a cycle.
//
// Ports
//   CLK           clock, all state on posedge
//   nRST          synchronous reset, active low
//   req_pend      [NREQ]      requester i wants to enqueue (level)
//   req_enq__ENA  [NREQ]      requester i fires enq (legal only with its RDY)
//   req_enq_v     [NREQ*DW]   payload, requester i at [i*DW +: DW]
//   req_enq__RDY  [NREQ]      requester i may fire this cycle
//   enq__RDY      FIFO not full
//   enq__ENA      FIFO enq fire
//   enq_v         [DW]        FIFO enq payload
//   owner         [IW]        index of current / last grant holder
//   busy          1 while a burst grant is held (HOLD)
// -----------------------------------------------------------------------------
module fifo1_enq_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 32,
    parameter int MAXBURST = 4,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NREQ-1:0]      req_pend,
    input  logic [NREQ-1:0]      req_enq__ENA,
    input  logic [NREQ*DW-1:0]   req_enq_v,
    output logic [NREQ-1:0]      req_enq__RDY,
    input  logic                 enq__RDY,
    output logic                 enq__ENA,
    output logic [DW-1:0]        enq_v,
    output logic [IW-1:0]        owner,
    output logic                 busy
);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0]    MAXB_C   = 8'(MAXBURST);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    // owner_q doubles as the "last grant" pointer: both are loaded with the
    // granted index on the same event and share the same reset value.
    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [7:0]    cnt_q,   cnt_d;

    logic [IW-1:0] arb_idx_s;
    logic          arb_found_s;
    logic [IW-1:0] gidx_s;
    logic          gvalid_s;
    logic          fire_s;

    // Rotating-priority search starting at the requester just after owner_q.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        arb_idx_s   = owner_q;
        arb_found_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(owner_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end else begin
                cand = cand;
            end
            cand_idx = cand[IW-1:0];
            if (!arb_found_s && req_pend[cand_idx]) begin
                arb_idx_s   = cand_idx;
                arb_found_s = 1'b1;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Grant selection: the burst owner keeps the grant in HOLD, otherwise the
    // search result. Depends only on registered state and req_pend.
    always_comb begin
        gidx_s   = arb_idx_s;
        gvalid_s = arb_found_s;
        if (state_q == HOLD) begin
            gidx_s   = owner_q;
            gvalid_s = req_pend[owner_q];
        end else begin
            gidx_s   = arb_idx_s;
            gvalid_s = arb_found_s;
        end
    end

    // Only the granted requester's ENA can ever reach the FIFO.
    assign fire_s = enq__RDY & req_enq__ENA[gidx_s] & gvalid_s;

    // Per-requester ready: at most one bit set, and only with FIFO space.
    always_comb begin
        req_enq__RDY = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_enq__RDY[i] = enq__RDY & gvalid_s & (gidx_s == IW'(i));
        end
    end

    // Forwarded FIFO method and status outputs.
    always_comb begin
        enq__ENA = fire_s;
        if (gvalid_s) begin
            enq_v = req_enq_v[gidx_s*DW +: DW];
        end else begin
            enq_v = {DW{1'b0}};
        end
        owner = owner_q;
        busy  = (state_q == HOLD);
    end

    // Next-state logic: grant capture, burst counting, early release.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB: begin
                if (fire_s) begin
                    owner_d = gidx_s;
                    cnt_d   = 8'd1;
                    state_d = (MAXBURST > 1) ? HOLD : ARB;
                end else begin
                    state_d = ARB;
                end
            end
            HOLD: begin
                // Owner dropping its request releases the grant even mid-burst.
                if (!req_pend[owner_q]) begin
                    state_d = ARB;
                    cnt_d   = 8'd0;
                end else if (fire_s) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == MAXB_C) begin
                        state_d = ARB;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    // FIFO full: keep the grant and the count.
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = ARB;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ARB;
            owner_q <= LAST_RST;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    fifo1_enq_arbiter_chk #(
        .NREQ (NREQ)
    ) u_chk (
        .CLK          (CLK),
        .nRST         (nRST),
        .req_enq__ENA (req_enq__ENA),
        .req_enq__RDY (req_enq__RDY)
    );

endmodule

// -----------------------------------------------------------------------------
// fifo1_enq_arbiter_chk
//   Protocol checker: a requester must never fire enq without its RDY.
// Ports
//   CLK, nRST      clock and synchronous active-low reset
//   req_enq__ENA   per-requester enq fire
//   req_enq__RDY   per-requester enq ready
// -----------------------------------------------------------------------------
module fifo1_enq_arbiter_chk #(
    parameter int NREQ = 4
) (
    input logic            CLK,
    input logic            nRST,
    input logic [NREQ-1:0] req_enq__ENA,
    input logic [NREQ-1:0] req_enq__RDY
);

    // ENA without RDY is ignored by the arbiter but flagged here.
    ena_needs_rdy_a : assert property (
        @(posedge CLK) disable iff (!nRST)
        ((req_enq__ENA & ~req_enq__RDY) == '0)
    ) else $error("fifo1_enq_arbiter: req_enq__ENA asserted without req_enq__RDY");

endmodule

// File: tb/tb_fifo1_enq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo1_enq_arbiter
//   Self-checking bench for fifo1_enq_arbiter. Two instances: "dut" with
//   MAXBURST=4 (vector table, burst/early-release/reset cases and a run
//   against a Fifo1 model) and "dut1" with MAXBURST=1 (pure round robin).
// -----------------------------------------------------------------------------
module tb_fifo1_enq_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic nRST = 1'b0;

    // dut (MAXBURST=4)
    logic [NREQ-1:0]    pend = '0, ena = '0, rdy;
    logic [NREQ*DW-1:0] v = '0;
    logic               frdy = 1'b1, fena;
    logic [DW-1:0]      fv;
    logic [1:0]         own;
    logic               busy;

    // dut1 (MAXBURST=1)
    logic [NREQ-1:0]    pend1 = '0, ena1 = '0, rdy1;
    logic [NREQ*DW-1:0] v1 = '0;
    logic               frdy1 = 1'b1, fena1;
    logic [DW-1:0]      fv1;
    logic [1:0]         own1;
    logic               busy1;

    fifo1_enq_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(4)) dut (
        .CLK(CLK), .nRST(nRST), .req_pend(pend), .req_enq__ENA(ena),
        .req_enq_v(v), .req_enq__RDY(rdy), .enq__RDY(frdy), .enq__ENA(fena),
        .enq_v(fv), .owner(own), .busy(busy)
    );

    fifo1_enq_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .req_pend(pend1), .req_enq__ENA(ena1),
        .req_enq_v(v1), .req_enq__RDY(rdy1), .enq__RDY(frdy1), .enq__ENA(fena1),
        .enq_v(fv1), .owner(own1), .busy(busy1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One table row: inputs applied after a posedge, outputs sampled before
    // the next one. v packs one payload byte per requester (r3 r2 r1 r0).
    typedef struct {
        logic        nrst;
        logic [3:0]  pend;
        logic        frdy;
        logic [3:0]  ena;
        logic [31:0] v;
        logic [3:0]  exp_rdy;
        logic        exp_ena;
        logic [7:0]  exp_v;
        logic [1:0]  exp_owner;
        logic        exp_busy;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    // Fifo1 model state and scoreboard
    logic        full, enq_now, deq_now;
    logic [31:0] fdata, enq_data, pay;
    logic [31:0] q [$];
    int          sent [NREQ];
    int          nenq, ndeq, viol, gi;

    initial begin
        //          nrst  pend     frdy  ena      v             rdy      ena   v      own   busy
        vt[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0}; // reset state
        vt[1]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 32'h00A00000, 4'b0100, 1'b1, 8'hA0, 2'd3, 1'b0}; // ARB grant 2
        vt[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00A10000, 4'b0100, 1'b1, 8'hA1, 2'd2, 1'b1}; // burst 2
        vt[3]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 32'h00A20000, 4'b0000, 1'b0, 8'hA2, 2'd2, 1'b1}; // FIFO full, hold
        vt[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00A20000, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1}; // burst 3
        vt[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00A30000, 4'b0100, 1'b1, 8'hA3, 2'd2, 1'b1}; // burst 4, end
        vt[6]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 32'hB0A40000, 4'b1000, 1'b1, 8'hB0, 2'd2, 1'b0}; // next is 3
        vt[7]  = '{1'b1, 4'b0011, 1'b1, 4'b0000, 32'hB1000000, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b1}; // owner 3 drops
        vt[8]  = '{1'b1, 4'b0010, 1'b1, 4'b0010, 32'h0000C000, 4'b0010, 1'b1, 8'hC0, 2'd3, 1'b0}; // grant 1
        vt[9]  = '{1'b1, 4'b0110, 1'b1, 4'b0010, 32'h0000C100, 4'b0010, 1'b1, 8'hC1, 2'd1, 1'b1}; // cnt -> 2
        vt[10] = '{1'b1, 4'b0100, 1'b1, 4'b0000, 32'h00D0C200, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1}; // owner 1 drops
        vt[11] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 32'h00D0C200, 4'b0100, 1'b1, 8'hD0, 2'd1, 1'b0}; // grant 2
        vt[12] = '{1'b0, 4'b0101, 1'b1, 4'b0000, 32'h00D100E0, 4'b0100, 1'b0, 8'hD1, 2'd2, 1'b1}; // reset in HOLD
        vt[13] = '{1'b1, 4'b0101, 1'b1, 4'b0001, 32'h00D100E0, 4'b0001, 1'b1, 8'hE0, 2'd3, 1'b0}; // search from 0
        vt[14] = '{1'b1, 4'b0101, 1'b1, 4'b0000, 32'h00D100E1, 4'b0001, 1'b0, 8'hE1, 2'd0, 1'b1}; // HOLD owner 0
        vt[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1}; // owner 0 drops
        vt[16] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 32'h77000000, 4'b0000, 1'b0, 8'h77, 2'd0, 1'b0}; // ARB, FIFO full

        // Reset both instances
        repeat (2) @(posedge CLK);

        // ---- Table-driven vectors on dut (MAXBURST=4) ----
        for (int r = 0; r < NV; r++) begin
            @(posedge CLK);
            #1;
            nRST = vt[r].nrst;
            pend = vt[r].pend;
            frdy = vt[r].frdy;
            ena  = vt[r].ena;
            for (int i = 0; i < NREQ; i++) begin
                v[i*DW +: DW] = {24'h000000, vt[r].v[i*8 +: 8]};
            end
            #2;
            check($sformatf("vec%0d_rdy", r),   32'(rdy),  32'(vt[r].exp_rdy));
            check($sformatf("vec%0d_ena", r),   32'(fena), 32'(vt[r].exp_ena));
            check($sformatf("vec%0d_v", r),     fv,        32'(vt[r].exp_v));
            check($sformatf("vec%0d_owner", r), 32'(own),  32'(vt[r].exp_owner));
            check($sformatf("vec%0d_busy", r),  32'(busy), 32'(vt[r].exp_busy));
        end
        @(posedge CLK);
        #1;
        pend = '0; ena = '0; frdy = 1'b1; nRST = 1'b1;

        // ---- Pure round robin on dut1 (MAXBURST=1): grants 0,1,2,3,0 ----
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK);
            #1;
            pend1 = 4'b1111;
            frdy1 = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                v1[i*DW +: DW] = 32'h100 + 32'(i);
            end
            #1;
            ena1 = rdy1;
            #1;
            check($sformatf("rr%0d_rdy", k),   32'(rdy1),  32'(4'b0001 << (k % 4)));
            check($sformatf("rr%0d_ena", k),   32'(fena1), 32'd1);
            check($sformatf("rr%0d_v", k),     fv1,        32'h100 + 32'(k % 4));
            check($sformatf("rr%0d_owner", k), 32'(own1),  32'((k + 3) % 4));
            check($sformatf("rr%0d_busy", k),  32'(busy1), 32'd0);
        end
        @(posedge CLK);
        #1;
        pend1 = '0; ena1 = '0;
        #1;
        check("rr_owner_final", 32'(own1), 32'd0);

        // ---- dut against a Fifo1 model, deq every 3rd cycle ----
        @(posedge CLK);
        #1;
        nRST = 1'b0; pend = '0; ena = '0; frdy = 1'b1;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        full = 1'b0; enq_now = 1'b0; deq_now = 1'b0; fdata = '0; enq_data = '0;
        nenq = 0; ndeq = 0; viol = 0;
        for (int i = 0; i < NREQ; i++) sent[i] = 0;

        for (int c = 0; c < 320; c++) begin
            @(posedge CLK);
            if (deq_now) begin
                if (q.size() > 0) begin
                    check("fifo_deq_data", fdata, q.pop_front());
                end else begin
                    check("fifo_deq_nonempty", 32'd0, 32'd1);
                end
                full = 1'b0;
                ndeq++;
            end
            if (enq_now) begin
                full  = 1'b1;
                fdata = enq_data;
            end
            #1;
            frdy    = ~full;
            deq_now = full && (c % 3 == 0);
            pend    = (c < 300) ? 4'($urandom_range(15, 0)) : 4'b0000;
            for (int i = 0; i < NREQ; i++) begin
                v[i*DW +: DW] = (32'(i) << 16) | 32'(sent[i]);
            end
            ena = '0;
            #1;
            ena = rdy;
            #1;
            enq_now  = fena;
            enq_data = fv;
            if (fena && !frdy) viol++;
            if (fena) begin
                gi = 0;
                for (int i = 0; i < NREQ; i++) begin
                    if (rdy[i[1:0]]) gi = i;
                end
                pay = (32'(gi) << 16) | 32'(sent[gi]);
                q.push_back(pay);
                sent[gi]++;
                nenq++;
            end
        end
        check("fifo_ena_without_rdy", 32'(viol), 32'd0);
        check("fifo_enq_eq_deq", 32'(nenq), 32'(ndeq));
        check("fifo_queue_empty", 32'(q.size()), 32'd0);
        check("fifo_traffic_seen", 32'(nenq >= 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
